// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - multiplexed common-anode 7-segment scan controller
// One shared hex decoder; digit data latched per frame so a frame never tears.
module sseg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int BLANK_CYC  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [NUM_DIGITS-1:0]   anode_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;
    // With no blank gap every slot opens straight into SHOW.
    localparam logic [1:0] S_SLOT0 = (BLANK_CYC == 0) ? S_SHOW : S_BLANK;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [1:0]              r_state;
    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_data_sh;
    logic [NUM_DIGITS-1:0]   r_blank_sh;
    logic [NUM_DIGITS-1:0]   r_dp_sh;

    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic [CW-1:0]           w_cnt_inc;
    logic [3:0]              w_digit;
    logic [NUM_DIGITS-1:0]   w_onehot;

    function automatic logic [6:0] sseg_dec(input logic [3:0] hex);
        case (hex)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            4'hF: return 7'b0111000;
        endcase
    endfunction

    assign w_slot_end = (r_state != S_IDLE) && (r_cnt == CNT_LAST);
    assign w_wrap     = w_slot_end && (r_idx == IDX_LAST) && en_i;
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_digit    = r_data_sh[{r_idx, 2'b00} +: 4];
    assign w_onehot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_data_sh  <= '0;
            r_blank_sh <= '0;
            r_dp_sh    <= '0;
        end else if (r_state == S_IDLE) begin
            if (en_i) begin
                r_data_sh  <= data_i;
                r_blank_sh <= blank_i;
                r_dp_sh    <= dp_i;
                r_idx      <= '0;
                r_cnt      <= '0;
                r_state    <= S_SLOT0;
            end
        end else if (!en_i) begin
            // Shadows are kept so a re-enable is the only thing that refreshes them.
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else if (w_slot_end) begin
            r_cnt   <= '0;
            r_state <= S_SLOT0;
            if (r_idx == IDX_LAST) begin
                r_idx      <= '0;
                r_data_sh  <= data_i;
                r_blank_sh <= blank_i;
                r_dp_sh    <= dp_i;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else begin
            r_cnt   <= w_cnt_inc;
            r_state <= (w_cnt_inc >= CNT_SHOW) ? S_SHOW : S_BLANK;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_anode <= '1;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_wrap;
            if ((r_state == S_SHOW) && !r_blank_sh[r_idx]) begin
                r_anode <= ~w_onehot;
                r_seg   <= sseg_dec(w_digit);
                r_dp    <= ~r_dp_sh[r_idx];
            end else begin
                r_anode <= '1;
                r_seg   <= 7'h7F;
                r_dp    <= 1'b1;
            end
        end
    end

    assign anode_o = r_anode;
    assign seg_o   = r_seg;
    assign dp_o    = r_dp;
    assign frame_o = r_frame;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - randomized bench for sseg_scan_ctrl against a time-based scan model
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  dp = '0;

    logic [3:0]  anode_a, anode_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b, frame_a, frame_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fr_q[$];

    // Model: per unit, time since scan start plus the snapshotted inputs.
    int          m_div [2] = '{8, 2};
    int          m_blk [2] = '{2, 0};
    bit          m_act [2];
    int          m_t   [2];
    logic [15:0] m_data[2];
    logic [3:0]  m_blank[2];
    logic [3:0]  m_dpm [2];

    sseg_scan_ctrl #(.NUM_DIGITS(4), .DIV(8), .BLANK_CYC(2)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .data_i(data), .blank_i(blank),
        .dp_i(dp), .anode_o(anode_a), .seg_o(seg_a), .dp_o(dp_a), .frame_o(frame_a)
    );

    sseg_scan_ctrl #(.NUM_DIGITS(4), .DIV(2), .BLANK_CYC(0)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .data_i(data), .blank_i(blank),
        .dp_i(dp), .anode_o(anode_b), .seg_o(seg_b), .dp_o(dp_b), .frame_o(frame_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  4'hF: return 7'b0111000;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic load_shadow(input int u);
        m_data[u]  = data;
        m_blank[u] = blank;
        m_dpm[u]   = dp;
    endtask

    task automatic tick();
        logic [3:0] ea, ga;
        logic [6:0] es, gs;
        logic       ed, ef, gd, gf;
        int         slot, off;
        string      sfx;
        @(posedge clk);
        #1;
        cyc++;
        for (int u = 0; u < 2; u++) begin
            ea = 4'hF; es = 7'h7F; ed = 1'b1; ef = 1'b0;
            if (rst_n && m_act[u]) begin
                slot = (m_t[u] / m_div[u]) % 4;
                off  = m_t[u] % m_div[u];
                if (off >= m_blk[u] && !m_blank[u][slot]) begin
                    ea = ~(4'b0001 << slot);
                    es = hex_seg(m_data[u][slot*4 +: 4]);
                    ed = ~m_dpm[u][slot];
                end
                ef = en && (slot == 3) && (off == m_div[u] - 1);
            end
            if (!rst_n) begin
                m_act[u] = 1'b0; m_t[u] = 0;
                m_data[u] = '0; m_blank[u] = '0; m_dpm[u] = '0;
            end else if (!m_act[u]) begin
                if (en) begin
                    m_act[u] = 1'b1; m_t[u] = 0;
                    load_shadow(u);
                end
            end else if (!en) begin
                m_act[u] = 1'b0; m_t[u] = 0;
            end else begin
                m_t[u] = (m_t[u] + 1) % (4 * m_div[u]);
                if (m_t[u] == 0) load_shadow(u);
            end
            ga  = (u == 0) ? anode_a : anode_b;
            gs  = (u == 0) ? seg_a   : seg_b;
            gd  = (u == 0) ? dp_a    : dp_b;
            gf  = (u == 0) ? frame_a : frame_b;
            sfx = (u == 0) ? "a" : "b";
            chk({"anode_", sfx}, 32'(ga), 32'(ea));
            chk({"seg_", sfx}, 32'(gs), 32'(es));
            chk({"dp_", sfx}, 32'(gd), 32'(ed));
            chk({"frame_", sfx}, 32'(gf), 32'(ef));
            chk({"onehot_", sfx}, 32'($countones(~ga) <= 1), 32'd1);
        end
        if (frame_a) fr_q.push_back(cyc);
    endtask

    task automatic wait_anode_a(input logic [3:0] target, input string tag);
        int n = 0;
        while (anode_a !== target && n < 200) begin
            tick();
            n++;
        end
        if (anode_a !== target) chk(tag, 32'(anode_a), 32'(target));
    endtask

    initial begin
        int first_lit;

        // reset
        tick(); tick();
        chk("rst_anode", 32'(anode_a), 32'hF);
        chk("rst_seg", 32'(seg_a), 32'h7F);
        chk("rst_dp", 32'(dp_a), 32'd1);
        chk("rst_frame", 32'(frame_a), 32'd0);

        // basic scan, first-lit latency and frame period
        rst_n = 1'b1; en = 1'b1; data = 16'h1234; blank = '0; dp = '0;
        fr_q.delete();
        first_lit = 0;
        for (int k = 1; k <= 72; k++) begin
            tick();
            if (first_lit == 0 && anode_a !== 4'hF) first_lit = k;
        end
        chk("first_lit", 32'(first_lit), 32'd4);
        if (fr_q.size() >= 2) chk("frame_per", 32'(fr_q[1] - fr_q[0]), 32'd32);
        else chk("frame_seen", 32'(fr_q.size()), 32'd2);

        // data change mid-frame must not tear
        wait_anode_a(4'b1101, "wait_d1");
        data = 16'hABCD;
        wait_anode_a(4'b1011, "wait_d2");
        chk("tear_d2", 32'(seg_a), 32'(7'b0010010));
        wait_anode_a(4'b1110, "wait_d0");
        chk("new_d0", 32'(seg_a), 32'(7'b1000010));
        repeat (40) tick();

        // blank and decimal point
        blank = 4'b0100; dp = 4'b0001; data = 16'h8888;
        repeat (40) tick();
        wait_anode_a(4'b1110, "wait_dp0");
        chk("dp_d0", 32'(dp_a), 32'd0);
        repeat (30) tick();

        // drop enable mid-SHOW of digit 2
        blank = '0; dp = 4'b1010;
        repeat (40) tick();
        wait_anode_a(4'b1011, "wait_en_d2");
        en = 1'b0;
        tick(); tick();
        chk("en_off_anode", 32'(anode_a), 32'hF);
        chk("en_off_seg", 32'(seg_a), 32'h7F);
        chk("en_off_frame", 32'(frame_a), 32'd0);
        repeat (5) tick();
        data = 16'h5A6F; en = 1'b1;
        repeat (40) tick();

        // one-edge reset mid-frame
        wait_anode_a(4'b1101, "wait_rst_d1");
        rst_n = 1'b0;
        tick();
        chk("mid_rst_anode", 32'(anode_a), 32'hF);
        chk("mid_rst_seg", 32'(seg_a), 32'h7F);
        chk("mid_rst_frame", 32'(frame_a), 32'd0);
        rst_n = 1'b1;
        repeat (50) tick();

        // random traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) data = 16'($urandom);
            if ($urandom_range(0, 19) == 0) blank = 4'($urandom & $urandom);
            if ($urandom_range(0, 9) == 0) dp = 4'($urandom);
            en    = ($urandom_range(0, 39) != 0);
            rst_n = ($urandom_range(0, 149) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
